// File: rtl/lsu_ctrl.sv
// Load/store unit: one core request -> one req/ack bus transaction -> aligned/extended writeback (LSU_MISALIGN_EN enables misalign trap).
// Latency: request edge -> lsu_done after 2 cycles with first-cycle ack; +1 cycle per ack wait cycle; misaligned trap 1 cycle.
// Backpressure: lsu_stall holds the core until lsu_done; mem_req/we/addr/wdata/be hold stable until mem_ack.
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] ld_data,
    output logic              lsu_done,
    output logic              lsu_stall,
    output logic              misalign_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic              err_q;
    logic              mis;
    logic [3:0]        be_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic [DATA_W-1:0] ld_nx;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              ld_sgn;

`ifdef LSU_MISALIGN_EN
    always_comb begin
        mis = 1'b0;
        case (lsu_funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = lsu_addr[0];
            default: mis = |lsu_addr[1:0];
        endcase
    end
`else
    assign mis = 1'b0;
`endif

    // Store lane steering: data replicated across lanes, enables pick the target bytes.
    always_comb begin
        be_nx    = 4'b0000;
        wdata_nx = rs2_data;
        case (lsu_funct3[1:0])
            2'b00: begin
                be_nx    = 4'b0001 << lsu_addr[1:0];
                wdata_nx = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                be_nx    = lsu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{rs2_data[15:0]}};
            end
            default: begin
                be_nx    = 4'b1111;
                wdata_nx = rs2_data;
            end
        endcase
        if (!lsu_we) be_nx = 4'b0000;
    end

    // Load alignment uses the captured low address bits, since mem_addr is word-aligned.
    always_comb begin
        ld_byte = mem_rdata[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_sgn  = ~f3_q[2];
        case (f3_q[1:0])
            2'b00:   ld_nx = {{24{ld_sgn & ld_byte[7]}}, ld_byte};
            2'b01:   ld_nx = {{16{ld_sgn & ld_half[15]}}, ld_half};
            default: ld_nx = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (lsu_req) state_nx = mis ? RESP : BUS;
            BUS:     if (mem_ack) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lsu_done     = (state == RESP);
        misalign_err = (state == RESP) & err_q;
    end

    assign lsu_stall = lsu_req & ~lsu_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            lo_q      <= 2'b00;
            err_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            ld_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req) begin
                        we_q    <= lsu_we;
                        f3_q    <= lsu_funct3;
                        lo_q    <= lsu_addr[1:0];
                        err_q   <= mis;
                        mem_req <= ~mis;
                        if (!mis) begin
                            mem_we    <= lsu_we;
                            mem_addr  <= {lsu_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= wdata_nx;
                            mem_be    <= be_nx;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!we_q) ld_data <= ld_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
